instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 The block SHALL have these ports:
- imem_req, output, 1: instruction-memory read request.
- imem_addr, output, 8: fetch address (equals PC).
- imem_ack, input, 1: read data valid this cycle.
- imem_rdata, input, 16: fetched instruction.
- opcode, output, 4: IR[15:12], drives control_unit opcode.
- ra, output, 4: IR[11:8].
- rb, output, 4: IR[7:4].
- imm, output, 4: IR[3:0].
- instr_valid, output, 1: decoded fields valid, held through EXEC.
- pc_select, input, 1: jump/branch class from control_unit.
- branch_taken, input, 1: datapath condition, sampled with exec_done.
- exec_done, input, 1: datapath finished current instruction.
- halted, output, 1: HALT state reached.
- pc, output, 8: current PC.

Function
REQ-003 The FSM SHALL have exactly four states, FETCH, DECODE, EXEC and HALT, with FETCH entered from reset.
REQ-004 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack.
REQ-005 On imem_ack=1 in FETCH, IR SHALL load imem_rdata at that edge and the state SHALL become DECODE; an ack in the same cycle as the first request SHALL be accepted.
REQ-006 imem_ack SHALL be ignored outside FETCH.
REQ-007 DECODE SHALL last exactly one cycle. If IR[15:12]=4'b1111, the next state SHALL be HALT; otherwise it SHALL be EXEC.
REQ-008 instr_valid SHALL be 1 in DECODE and EXEC and 0 otherwise. opcode/ra/rb/imm SHALL reflect IR continuously.
REQ-009 The block SHALL stay in EXEC until exec_done=1, then at that edge update PC and enter FETCH.
REQ-010 The PC update at exec_done SHALL be: if pc_select=1 and branch_taken=1, PC = {ra,rb} (absolute 8-bit target); otherwise PC = PC+1 modulo 256.
REQ-011 PC wrap-around SHALL be: 8'hFF+1 -> 8'h00, with no flag.
REQ-012 The minimum instruction latency SHALL be 3 cycles: FETCH (ack same cycle), DECODE, EXEC (exec_done same cycle).
REQ-013 HALT SHALL be absorbing: halted=1, imem_req=0, instr_valid=0, and PC/IR frozen until rst.
REQ-014 pc_select and branch_taken SHALL be ignored except at the exec_done edge in EXEC.

Reset
REQ-015 While rst=1 at a clock edge, the next state SHALL be: state=FETCH, pc=8'h00, IR=16'h0000, halted=0, instr_valid=0. rst SHALL take priority over all other inputs.
REQ-016 imem_req SHALL be 0 during the cycle rst is asserted, and SHALL reassert in the first cycle after rst deasserts.
REQ-017 Reset mid-FETCH SHALL discard any imem_ack arriving in the rst cycle. Reset mid-EXEC SHALL discard exec_done, with no PC update.

Structure
REQ-018 A shared package SHALL hold: the PC width (8) and instruction width (16), the opcode field position, the HALT opcode 4'b1111, and the FSM state enum.
REQ-019 The block SHALL be a single module with no sub-module: state register, PC register and IR only.

Verification
REQ-020 Reset then ack on the first cycle with rdata=16'h1123 -> opcode=4'h1, ra=1, rb=2, imm=3; instr_valid high one cycle after ack; exec_done -> pc=8'h01, imem_req=1.
REQ-021 imem_ack delayed 4 cycles -> imem_addr constant and IR unchanged until ack; acks injected in EXEC -> no effect.
REQ-022 rdata=16'h7A5C, pc_select=1, branch_taken=1 at exec_done -> pc=8'hA5. Same with branch_taken=0 -> pc=old+1.
REQ-023 pc=8'hFF, non-branch, exec_done -> pc=8'h00.
REQ-024 rdata=16'hF000 -> halted=1 two cycles after ack; imem_req stays 0 for 20 cycles; rst -> pc=8'h00, FETCH.
REQ-025 rst asserted in the same cycle as imem_ack (or exec_done) -> IR=0, pc=0, next cycle FETCH with imem_addr=8'h00.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch/decode sequencer.
// Holds the PC and instruction widths, the instruction field positions,
// the HALT opcode and the FSM state encoding.
package instruction_fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int FLD_W   = 4;

  // Instruction layout: {opcode, ra, rb, imm}, each FLD_W bits
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 4;
  localparam int IMM_LSB = 0;

  localparam logic [FLD_W-1:0] HALT_OPC = 4'b1111;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Purpose: fetch/decode sequencer with PC and instruction register.
// Latency: 3 cycles minimum per instruction (FETCH, DECODE, EXEC).
// Backpressure: stalls in FETCH until imem_ack, in EXEC until exec_done.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [FLD_W-1:0]    opcode,
  output logic [FLD_W-1:0]    ra,
  output logic [FLD_W-1:0]    rb,
  output logic [FLD_W-1:0]    imm,
  output logic                instr_valid,
  input  logic                pc_select,
  input  logic                branch_taken,
  input  logic                exec_done,
  output logic                halted,
  output logic [PC_W-1:0]     pc
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                w_ir_load;
  logic                w_pc_upd;
  logic [PC_W-1:0]     w_pc_next;

  // Next-state logic; IR load and PC update strobes only fire in their own state,
  // so ack outside FETCH and branch inputs outside the exec_done edge are ignored
  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_pc_upd    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (imem_ack) begin
          w_ir_load   = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (r_ir[OPC_MSB:OPC_LSB] == HALT_OPC) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          w_pc_upd    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Taken branch jumps to the absolute target {ra,rb}; otherwise step, wrapping at 8 bits
  always_comb begin
    w_pc_next = r_pc + PC_W'(1);
    if (pc_select && branch_taken) begin
      w_pc_next = r_ir[RA_LSB+FLD_W-1:RB_LSB];
    end
  end

  // State, PC and IR registers; reset overrides any ack or exec_done in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ir_load) begin
        r_ir <= imem_rdata;
      end
      if (w_pc_upd) begin
        r_pc <= w_pc_next;
      end
    end
  end

  // Request is masked by rst so nothing is issued during the reset cycle
  assign imem_req    = (r_state == S_FETCH) && !rst;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign opcode      = r_ir[OPC_MSB:OPC_LSB];
  assign ra          = r_ir[RA_LSB+FLD_W-1:RA_LSB];
  assign rb          = r_ir[RB_LSB+FLD_W-1:RB_LSB];
  assign imm         = r_ir[IMM_LSB+FLD_W-1:IMM_LSB];
  assign instr_valid = (r_state == S_DECODE) || (r_state == S_EXEC);
  assign halted      = (r_state == S_HALT);

endmodule
